// File: rtl/pic_pkg.sv
`default_nettype none
// pic_pkg: shared widths, acknowledge-state encoding and priority helper for the 8259 acknowledge path.
package pic_pkg;

  localparam int IR_W = 8;
  localparam int ID_W = 3;
  localparam logic [ID_W-1:0] SPURIOUS_ID = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK1  = 2'd1,
    WAIT2 = 2'd2,
    ACK2  = 2'd3
  } state_t;

  // Index of the lowest set bit (IR0 has the highest priority); 0 when v is empty.
  function automatic logic [ID_W-1:0] prio_first(input logic [IR_W-1:0] v);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = IR_W - 1; i >= 0; i--) begin
      if (v[i]) idx = ID_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_resolver.sv
`default_nettype none
// prio_resolver: fixed-priority pick of the highest pending candidate and the highest in-service level.
module prio_resolver
  import pic_pkg::*;
(
  input  logic [IR_W-1:0] cand,
  input  logic [IR_W-1:0] isr,
  output logic [ID_W-1:0] req_id,
  output logic            req_valid,
  output logic [ID_W-1:0] isr_top_id,
  output logic            isr_any
);

  assign req_id     = prio_first(cand);
  assign req_valid  = |cand;
  assign isr_top_id = prio_first(isr);
  assign isr_any    = |isr;

endmodule
`default_nettype wire

// File: rtl/inta_sequencer.sv
`default_nettype none
// inta_sequencer: resolves pending IRQs, raises int_out and steps through the two INTA cycles,
// maintaining the in-service register and driving the vector byte in the second cycle.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inta_n,
  input  logic [IR_W-1:0] irq_pend,
  input  logic [IR_W-1:0] imr,
  input  logic [4:0]      vec_base,
  input  logic            sngl,
  input  logic            sp,
  input  logic [IR_W-1:0] slave_map,
  input  logic            aeoi,
  input  logic            eoi,
  input  logic            vec_flag,
  output logic            int_out,
  output logic            pulse1,
  output logic            pulse2,
  output logic [ID_W-1:0] intr_id,
  output logic [IR_W-1:0] isr,
  output logic [IR_W-1:0] irr_clr,
  output logic [7:0]      data_out,
  output logic            data_oe
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   inta_s;
  state_t                 state, state_nxt;
  logic                   spurious_q;

  logic [IR_W-1:0] cand;
  logic [ID_W-1:0] req_id, isr_top_id;
  logic            req_valid, isr_any;
  logic            ack1_entry, ack2_exit, drive_nxt;
  logic [IR_W-1:0] set_mask, eoi_mask, aeoi_mask;

  // Synchronizer idles high so reset never looks like an acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], inta_n};
  end
  assign inta_s = sync_q[SYNC_STAGES-1];

  assign cand = irq_pend & ~imr;

  prio_resolver u_prio (
    .cand       (cand),
    .isr        (isr),
    .req_id     (req_id),
    .req_valid  (req_valid),
    .isr_top_id (isr_top_id),
    .isr_any    (isr_any)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!inta_s) state_nxt = ACK1;
      ACK1:    if (inta_s)  state_nxt = WAIT2;
      WAIT2:   if (!inta_s) state_nxt = ACK2;
      ACK2:    if (inta_s)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ack1_entry = (state == IDLE) && !inta_s;
  assign ack2_exit  = (state == ACK2) && inta_s;

  // EOI clears act on the pre-set ISR; the ACK1 set is OR-ed in afterwards.
  assign set_mask  = (ack1_entry && req_valid) ? (IR_W'(1) << req_id) : '0;
  assign eoi_mask  = (eoi && isr_any) ? (IR_W'(1) << isr_top_id) : '0;
  assign aeoi_mask = (aeoi && ack2_exit && !spurious_q) ? (IR_W'(1) << intr_id) : '0;

  assign drive_nxt = sngl | (sp & ~slave_map[intr_id]) | (~sp & vec_flag);

  assign int_out = (state == IDLE) && req_valid && (!isr_any || (req_id < isr_top_id));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      isr        <= '0;
      intr_id    <= '0;
      spurious_q <= 1'b0;
      irr_clr    <= '0;
      pulse1     <= 1'b0;
      pulse2     <= 1'b0;
      data_out   <= '0;
      data_oe    <= 1'b0;
    end else begin
      state   <= state_nxt;
      isr     <= (isr & ~(eoi_mask | aeoi_mask)) | set_mask;
      irr_clr <= set_mask;
      pulse1  <= (state_nxt == ACK1);
      pulse2  <= (state_nxt == ACK2);
      if (ack1_entry) begin
        intr_id    <= req_valid ? req_id : SPURIOUS_ID;
        spurious_q <= !req_valid;
      end
      data_oe  <= (state_nxt == ACK2) && drive_nxt;
      data_out <= (state_nxt == ACK2) ? {vec_base, intr_id} : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inta_sequencer.sv
`default_nettype none
// tb_inta_sequencer: directed, self-checking bench for the INTA sequencer.
module tb_inta_sequencer;

  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inta_n;
  logic [7:0] irq_pend, imr, slave_map;
  logic [4:0] vec_base;
  logic       sngl, sp, aeoi, eoi, vec_flag;
  logic       int_out, pulse1, pulse2, data_oe;
  logic [2:0] intr_id;
  logic [7:0] isr, irr_clr, data_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] pend;
    logic [7:0] mask;
    logic       exp_int;
  } vec_t;
  vec_t vecs[6];

  inta_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .irq_pend(irq_pend), .imr(imr),
    .vec_base(vec_base), .sngl(sngl), .sp(sp), .slave_map(slave_map), .aeoi(aeoi),
    .eoi(eoi), .vec_flag(vec_flag), .int_out(int_out), .pulse1(pulse1), .pulse2(pulse2),
    .intr_id(intr_id), .isr(isr), .irr_clr(irr_clr), .data_out(data_out), .data_oe(data_oe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Drive inta_n and wait until the synchronized level has moved the FSM.
  task automatic ack_step(input logic lvl);
    inta_n = lvl;
    repeat (SYNC + 1) tick();
  endtask

  task automatic eoi_pulse();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h00, 1'b0};
    vecs[1] = '{8'h28, 8'h00, 1'b1};
    vecs[2] = '{8'h28, 8'h28, 1'b0};
    vecs[3] = '{8'h28, 8'h20, 1'b1};
    vecs[4] = '{8'h80, 8'h7F, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0};

    rst_n = 1'b0; inta_n = 1'b1; irq_pend = 8'h00; imr = 8'h00; slave_map = 8'h00;
    vec_base = 5'b01000; sngl = 1'b1; sp = 1'b1; aeoi = 1'b0; eoi = 1'b0; vec_flag = 1'b0;
    repeat (3) tick();
    check("rst_isr", 32'(isr), 32'h00);
    check("rst_id", 32'(intr_id), 32'h0);
    check("rst_pulses", {30'd0, pulse1, pulse2}, 32'h0);
    check("rst_data", {23'd0, data_oe, data_out}, 32'h0);
    check("rst_irr_clr", 32'(irr_clr), 32'h00);
    check("rst_int", 32'(int_out), 32'h0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      irq_pend = vecs[i].pend;
      imr = vecs[i].mask;
      #1;
      check($sformatf("vec%0d_int", i), 32'(int_out), 32'(vecs[i].exp_int));
    end

    // Single mode basic acknowledge, with explicit latency check.
    irq_pend = 8'h28; imr = 8'h00;
    #1 check("basic_int", 32'(int_out), 32'h1);
    inta_n = 1'b0;
    repeat (SYNC) tick();
    check("latency_pulse1_low", 32'(pulse1), 32'h0);
    tick();
    check("ack1_pulse1", 32'(pulse1), 32'h1);
    check("ack1_id", 32'(intr_id), 32'h3);
    check("ack1_irr_clr", 32'(irr_clr), 32'h08);
    check("ack1_isr", 32'(isr), 32'h08);
    check("ack1_int_low", 32'(int_out), 32'h0);
    tick();
    check("irr_clr_one_cycle", 32'(irr_clr), 32'h00);
    check("ack1_pulse1_hold", 32'(pulse1), 32'h1);
    ack_step(1'b1);
    check("wait2_pulses", {30'd0, pulse1, pulse2}, 32'h0);
    ack_step(1'b0);
    check("ack2_pulse2", 32'(pulse2), 32'h1);
    check("ack2_data", 32'(data_out), 32'h43);
    check("ack2_oe", 32'(data_oe), 32'h1);
    ack_step(1'b1);
    check("idle_pulse2", 32'(pulse2), 32'h0);
    check("idle_oe", 32'(data_oe), 32'h0);
    check("idle_isr_kept", 32'(isr), 32'h08);
    check("idle_int_same_level", 32'(int_out), 32'h0);

    // Priority masking against ISR and non-specific EOI.
    eoi_pulse();
    check("eoi_clear", 32'(isr), 32'h00);
    check("eoi_int", 32'(int_out), 32'h1);
    irq_pend = 8'h04;
    ack_step(1'b0); ack_step(1'b1); ack_step(1'b0); ack_step(1'b1);
    check("prio_isr", 32'(isr), 32'h04);
    irq_pend = 8'h10;
    #1 check("prio_int_blocked", 32'(int_out), 32'h0);
    irq_pend = 8'h03;
    #1 check("prio_int_higher", 32'(int_out), 32'h1);
    irq_pend = 8'h10;
    eoi_pulse();
    check("prio_eoi_isr", 32'(isr), 32'h00);
    check("prio_eoi_int", 32'(int_out), 32'h1);
    eoi_pulse();
    check("eoi_empty_isr", 32'(isr), 32'h00);

    // Automatic EOI.
    aeoi = 1'b1; irq_pend = 8'h01;
    ack_step(1'b0); ack_step(1'b1); ack_step(1'b0);
    check("aeoi_isr_in_ack2", 32'(isr), 32'h01);
    inta_n = 1'b1;
    repeat (SYNC) tick();
    check("aeoi_isr_before_exit", 32'(isr), 32'h01);
    tick();
    check("aeoi_isr_after_exit", 32'(isr), 32'h00);
    check("aeoi_pulse2_low", 32'(pulse2), 32'h0);

    // Cascade master: slave on IR2 drives the vector.
    sngl = 1'b0; sp = 1'b1; slave_map = 8'h04; irq_pend = 8'h04;
    ack_step(1'b0);
    check("master_id", 32'(intr_id), 32'h2);
    check("master_pulse1", 32'(pulse1), 32'h1);
    ack_step(1'b1); ack_step(1'b0);
    check("master_pulse2", 32'(pulse2), 32'h1);
    check("master_oe", 32'(data_oe), 32'h0);
    ack_step(1'b1);

    // Cascade slave addressed by the master.
    sp = 1'b0; vec_flag = 1'b1;
    ack_step(1'b0); ack_step(1'b1); ack_step(1'b0);
    check("slave_oe", 32'(data_oe), 32'h1);
    check("slave_data", 32'(data_out), 32'h42);
    vec_flag = 1'b0;
    tick();
    check("slave_oe_dropped", 32'(data_oe), 32'h0);
    ack_step(1'b1);

    // Spurious: request withdrawn before the first INTA is seen.
    sngl = 1'b1; sp = 1'b1; aeoi = 1'b0; irq_pend = 8'h08;
    #1 check("spur_int_before", 32'(int_out), 32'h1);
    irq_pend = 8'h00;
    ack_step(1'b0);
    check("spur_id", 32'(intr_id), 32'h7);
    check("spur_irr_clr", 32'(irr_clr), 32'h00);
    check("spur_isr", 32'(isr), 32'h00);
    ack_step(1'b1); ack_step(1'b0);
    check("spur_data", 32'(data_out), 32'h47);
    ack_step(1'b1);

    // Reset during WAIT2, then a fresh acknowledge.
    irq_pend = 8'h02;
    ack_step(1'b0);
    check("pre_rst_isr", 32'(isr), 32'h02);
    ack_step(1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_isr", 32'(isr), 32'h00);
    check("midrst_id", 32'(intr_id), 32'h0);
    check("midrst_regs", {14'd0, pulse1, pulse2, irr_clr, data_oe, data_out[6:0]}, 32'h0);
    check("midrst_data", 32'(data_out), 32'h00);
    tick();
    rst_n = 1'b1;
    tick();
    ack_step(1'b0);
    check("post_rst_id", 32'(intr_id), 32'h1);
    check("post_rst_irr_clr", 32'(irr_clr), 32'h02);
    ack_step(1'b1); ack_step(1'b0);
    check("post_rst_data", 32'(data_out), 32'h41);
    check("post_rst_oe", 32'(data_oe), 32'h1);
    ack_step(1'b1);
    check("post_rst_isr", 32'(isr), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inta_sequencer.md
# inta_sequencer

Interrupt-acknowledge sequencer for the 8259 PIC. It resolves fixed-priority pending requests against the mask and in-service register and raises `int_out`. It then tracks the CPU's two INTA strobes, generating the `pulse1`/`pulse2`/`intr_id` inputs consumed by the cascade block. It also drives the vector byte in the second cycle, gated by the cascade block's `vec_flag`.

## Interface
Parameters:
- SYNC_STAGES, 2, flops in the `inta_n` synchronizer (≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inta_n  in  1  CPU acknowledge strobe, asynchronous, synchronized internally
- irq_pend  in  8  IRR contents, IR0 = bit 0
- imr  in  8  interrupt mask, 1 = masked
- vec_base  in  5  ICW2 T7..T3
- sngl  in  1  single mode (no cascade)
- sp  in  1  1 = master, 0 = slave
- slave_map  in  8  ICW3 (master): 1 = slave on that IR
- aeoi  in  1  automatic EOI enable
- eoi  in  1  one-cycle non-specific EOI command
- vec_flag  in  1  cascade block: this slave is addressed
- int_out  out  1  interrupt request to CPU/master
- pulse1  out  1  high during first acknowledge
- pulse2  out  1  high during second acknowledge
- intr_id  out  3  latched IR number being acknowledged
- isr  out  8  in-service register
- irr_clr  out  8  one-cycle clear strobe to IRR
- data_out  out  8  vector byte
- data_oe  out  1  data_out drive enable

## Operation
- Candidates: `cand = irq_pend & ~imr`. Priority is fixed; IR0 is highest.
- `int_out` is 1 in IDLE when the highest candidate is strictly higher than the highest set `isr` bit, and when no `isr` bit is set and `cand != 0`.
- States:
  - IDLE → ACK1 when synchronized inta is low.
  - ACK1 → WAIT2 on inta high.
  - WAIT2 → ACK2 on inta low.
  - ACK2 → IDLE on inta high.
- Entering ACK1:
  - Latch `intr_id` = highest candidate.
  - Set `isr[id]`.
  - Pulse `irr_clr[id]` for one cycle.
  - If `cand == 0`, the acknowledge is spurious: `id = 7`, no `isr` set, no clear.
- `pulse1` is 1 exactly in ACK1. `pulse2` is 1 exactly in ACK2. `int_out` is 0 outside IDLE.
- ACK2 drive condition: `data_oe = 1` when `sngl`, or (`sp` and `!slave_map[id]`), or (`!sp` and `vec_flag`). Otherwise `data_oe = 0` and the cascaded slave drives.
- Vector: `data_out = {vec_base, intr_id}`.
- AEOI: on the ACK2 → IDLE transition, clear `isr[intr_id]` (skipped if spurious).
- `eoi`: clears the highest-priority set `isr` bit. No effect if `isr == 0`.
- Simultaneous AEOI clear and `eoi` in the same cycle: both clear masks are OR-ed. A set and an EOI clear cannot coincide (set happens only on ACK1 entry; if `eoi` arrives then, apply the clear to the pre-set `isr`, then the set).
- Candidates changing after ACK1 entry do not alter the latched `intr_id`.

## Timing
- Reset values: state IDLE, `isr = 0`, `intr_id = 0`, `int_out = 0`, `pulse1 = 0`, `pulse2 = 0`, `irr_clr = 0`, `data_out = 0`, `data_oe = 0`, synchronizer flops = 1.
- Reset mid-acknowledge returns immediately to IDLE with all outputs at reset values.
- Latency: if rising edge k is the first to sample `inta_n` low, the state changes (and `pulse1`/`pulse2` rise) at edge k + SYNC_STAGES. Release follows with the same latency.
- All outputs are registered except `int_out`, which is combinational from registered state and the inputs.
- `irr_clr` is high for exactly one cycle, coincident with the first ACK1 cycle.
- `data_oe` and `data_out` are valid from the first ACK2 cycle. `vec_flag` is sampled every ACK2 cycle.

## Structure
- Shared package `pic_pkg`:
  - state enum (IDLE, ACK1, WAIT2, ACK2)
  - `IR_W = 8`, `ID_W = 3`, `SPURIOUS_ID = 3'd7`
  - `prio_first(v)` function returning the index of the lowest set bit
- One sub-module: `prio_resolver`, combinational. Takes `cand` and `isr`; outputs `req_id`, `req_valid`, `isr_top_id`, `isr_any`.
- The synchronizer is inline.

## Test plan
- Single mode, `vec_base = 5'b01000`, `irq_pend = 8'h28`, `imr = 0`:
  - `int_out = 1`.
  - Two INTA strobes → `intr_id = 3`, `irr_clr = 8'h08` for one cycle, `isr = 8'h08`.
  - `data_out = 8'h43` with `data_oe = 1` in ACK2.
- Priority masking: `isr = 8'h04`, `irq_pend = 8'h10` → `int_out = 0`.
  - `eoi` pulse → `isr = 0`, `int_out = 1`.
- AEOI: `aeoi = 1`, `irq_pend = 8'h01`, full acknowledge → `isr` returns to 0 on the ACK2 → IDLE edge.
- Master with `slave_map = 8'h04`, `irq_pend = 8'h04`: `intr_id = 2`, `pulse1`/`pulse2` assert, `data_oe = 0` in ACK2.
  - Slave (`sp = 0`) with `vec_flag = 1`: `data_oe = 1`.
- Spurious: `irq_pend` drops to 0 before the first INTA → `intr_id = 7`, `isr` unchanged, `irr_clr = 0`, `data_out = {vec_base, 3'd7}`.
- Assert `rst_n` low during WAIT2 → all outputs at reset values immediately; the next INTA pair is handled from IDLE.
